// File: rtl/comm_pkg.sv
// comm_pkg: state encodings and shared constants for the UART frame-buffer
// write and read address sequencers.
package comm_pkg;
   typedef enum logic [2:0] {IDLE, ARM, SETUP, PULSE, NEXT, DONE} state_t;
   localparam int NCH       = 5;
   localparam int WORDS_DEF = 20;
   localparam int AW_DEF    = 5;
endpackage

// File: rtl/comm_wr_chan.sv
// comm_wr_chan: single-channel frame write sequencer (strobe sync, FSM, address).
// Optional inter-byte gap timeout enabled by defining WR_TIMEOUT_EN.
module comm_wr_chan
   import comm_pkg::*;
#(
   parameter int WORDS    = WORDS_DEF,
   parameter int AW       = AW_DEF,
   parameter int WR_SETUP = 2,
   parameter int WR_WIDTH = 4,
   parameter int TIMEOUT  = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          strob,
   input  logic          rx_valid,
   output logic          wr,
   output logic [AW-1:0] adr,
   output logic          frame_done,
   output logic          overrun,
   output logic          short_frame
);
   state_t        st, st_n;
   logic [1:0]    s;
   logic [AW-1:0] cnt, cnt_n, adr_n;
   logic [7:0]    tmr, tmr_n;
   logic          fd_n, ov_n, sf_n;
`ifdef WR_TIMEOUT_EN
   logic [15:0]   gap, gap_n;
`endif

   if (WORDS < 1 || WORDS > 2**AW || WR_SETUP < 1 || WR_WIDTH < 1 || TIMEOUT < 1) begin : g_bad
      $error("comm_wr_chan: illegal parameter set");
   end

   assign wr = st == PULSE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st          <= IDLE;
         s           <= '0;
         cnt         <= '0;
         adr         <= '0;
         tmr         <= '0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         short_frame <= 1'b0;
`ifdef WR_TIMEOUT_EN
         gap         <= '0;
`endif
      end else begin
         st          <= st_n;
         s           <= {s[0], strob};
         cnt         <= cnt_n;
         adr         <= adr_n;
         tmr         <= tmr_n;
         frame_done  <= fd_n;
         overrun     <= ov_n;
         short_frame <= sf_n;
`ifdef WR_TIMEOUT_EN
         gap         <= gap_n;
`endif
      end

   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      adr_n = adr;
      tmr_n = tmr;
      fd_n  = 1'b0;
      ov_n  = 1'b0;
      sf_n  = 1'b0;
`ifdef WR_TIMEOUT_EN
      gap_n = '0;
`endif
      case (st)
         IDLE: begin
            cnt_n = '0;
            adr_n = '0;
            if (s[1]) st_n = ARM;
         end
         ARM:
            if (rx_valid) begin
               st_n  = SETUP;
               tmr_n = '0;
               adr_n = cnt;
            end else if (!s[1]) begin
               sf_n = cnt != '0;
               st_n = IDLE;
            end
`ifdef WR_TIMEOUT_EN
            // stalled partial frame: abandon it but keep the window armed
            else if (cnt != '0) begin
               if (gap == 16'(TIMEOUT - 1)) begin
                  sf_n  = 1'b1;
                  cnt_n = '0;
               end else gap_n = gap + 16'd1;
            end
`endif
         SETUP: begin
            ov_n = rx_valid;
            st_n  = tmr == 8'(WR_SETUP - 1) ? PULSE : SETUP;
            tmr_n = tmr == 8'(WR_SETUP - 1) ? '0 : tmr + 8'd1;
         end
         PULSE: begin
            ov_n = rx_valid;
            st_n  = tmr == 8'(WR_WIDTH - 1) ? NEXT : PULSE;
            tmr_n = tmr == 8'(WR_WIDTH - 1) ? '0 : tmr + 8'd1;
         end
         NEXT: begin
            ov_n = rx_valid;
            fd_n  = cnt == AW'(WORDS - 1);
            st_n  = fd_n ? DONE : ARM;
            cnt_n = fd_n ? '0 : cnt + AW'(1);
         end
         DONE: begin
            ov_n = rx_valid;
            if (!s[1]) st_n = IDLE;
         end
         default: st_n = IDLE;
      endcase
   end
endmodule

// File: rtl/comm_wr_adr.sv
// comm_wr_adr: five independent frame write sequencers feeding the frame RAMs.
// Optional inter-byte gap timeout enabled by defining WR_TIMEOUT_EN.
module comm_wr_adr
   import comm_pkg::*;
#(
   parameter int WORDS    = WORDS_DEF,
   parameter int AW       = AW_DEF,
   parameter int WR_SETUP = 2,
   parameter int WR_WIDTH = 4,
   parameter int TIMEOUT  = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    strob,
   input  logic [NCH-1:0]    rxValid,
   output logic [NCH-1:0]    WR,
   output logic [NCH*AW-1:0] WrAdr,
   output logic [NCH-1:0]    frameDone,
   output logic [NCH-1:0]    overrun,
   output logic [NCH-1:0]    shortFrame
);
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      comm_wr_chan #(
         .WORDS(WORDS), .AW(AW), .WR_SETUP(WR_SETUP), .WR_WIDTH(WR_WIDTH), .TIMEOUT(TIMEOUT)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .strob      (strob[g]),
         .rx_valid   (rxValid[g]),
         .wr         (WR[g]),
         .adr        (WrAdr[g*AW +: AW]),
         .frame_done (frameDone[g]),
         .overrun    (overrun[g]),
         .short_frame(shortFrame[g])
      );
   end
endmodule

// File: tb/tb_comm_wr_adr.sv
// tb_comm_wr_adr: directed self-checking bench for comm_wr_adr.
// Timeout scenario expectations follow WR_TIMEOUT_EN.
module tb_comm_wr_adr;
   localparam int AW = 5;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    strob = '0;
   logic [4:0]    rxValid = '0;
   logic [4:0]    WR, frameDone, overrun, shortFrame;
   logic [5*AW-1:0] WrAdr;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   comm_wr_adr #(.WORDS(20), .AW(AW), .WR_SETUP(2), .WR_WIDTH(4), .TIMEOUT(50)) dut (
      .clk(clk), .rst(rst), .strob(strob), .rxValid(rxValid), .WR(WR), .WrAdr(WrAdr),
      .frameDone(frameDone), .overrun(overrun), .shortFrame(shortFrame)
   );

   function automatic logic [AW-1:0] adr(input int c);
      return WrAdr[c*AW +: AW];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse(input logic [4:0] m);
      rxValid = m;
      tick();
      rxValid = '0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_cmp++; if ({WR, frameDone, overrun, shortFrame} !== 20'h0) begin n_err++; $display("FAIL reset_flags got %h want 0", {WR, frameDone, overrun, shortFrame}); end
      n_cmp++; if (WrAdr !== '0) begin n_err++; $display("FAIL reset_adr got %h want 0", WrAdr); end
      rst = 1'b0;
      repeat (2) tick();
      n_cmp++; if ({WR, WrAdr} !== '0) begin n_err++; $display("FAIL post_reset got %h want 0", {WR, WrAdr}); end
   endtask

   task automatic test_nominal();
      logic ew;
      strob[0] = 1'b1;
      repeat (5) tick();
      for (int b = 0; b < 20; b++) begin
         pulse(5'b00001);
         for (int k = 1; k <= 9; k++) begin
            ew = k >= 3 && k <= 6;
            n_cmp++; if (WR[0] !== ew) begin n_err++; $display("FAIL nom_wr b=%0d k=%0d got %b want %b", b, k, WR[0], ew); end
            if (ew) begin
               n_cmp++; if (adr(0) !== 5'(b)) begin n_err++; $display("FAIL nom_adr b=%0d got %0d want %0d", b, adr(0), b); end
            end
            n_cmp++; if (frameDone[0] !== (b == 19 && k == 8)) begin n_err++; $display("FAIL nom_done b=%0d k=%0d got %b", b, k, frameDone[0]); end
            tick();
         end
      end
      strob[0] = 1'b0;
      repeat (6) tick();
      n_cmp++; if (adr(0) !== 5'd0) begin n_err++; $display("FAIL nom_idle_adr got %0d want 0", adr(0)); end
   endtask

   task automatic test_overrun();
      int wc, oc, sc;
      strob[2] = 1'b1;
      repeat (5) tick();
      wc = 0; oc = 0;
      pulse(5'b00100);
      for (int k = 1; k <= 11; k++) begin
         wc += int'(WR[2]); oc += int'(overrun[2]);
         if (WR[2]) begin
            n_cmp++; if (adr(2) !== 5'd0) begin n_err++; $display("FAIL ovr_adr0 got %0d want 0", adr(2)); end
         end
         rxValid = k == 3 ? 5'b00100 : 5'b0;
         tick();
      end
      n_cmp++; if (wc !== 4) begin n_err++; $display("FAIL ovr_wr_cycles got %0d want 4", wc); end
      n_cmp++; if (oc !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", oc); end
      wc = 0;
      pulse(5'b00100);
      for (int k = 1; k <= 8; k++) begin
         wc += int'(WR[2]);
         if (WR[2]) begin
            n_cmp++; if (adr(2) !== 5'd1) begin n_err++; $display("FAIL ovr_adr1 got %0d want 1", adr(2)); end
         end
         tick();
      end
      n_cmp++; if (wc !== 4) begin n_err++; $display("FAIL ovr_wr2_cycles got %0d want 4", wc); end
      strob[2] = 1'b0;
      sc = 0;
      for (int k = 0; k < 6; k++) begin tick(); sc += int'(shortFrame[2]); end
      n_cmp++; if (sc !== 1) begin n_err++; $display("FAIL ovr_close_short got %0d want 1", sc); end
   endtask

   task automatic test_short();
      int wc, sc, dc;
      strob[3] = 1'b1;
      repeat (5) tick();
      wc = 0; sc = 0; dc = 0;
      for (int b = 0; b < 7; b++) begin
         pulse(5'b01000);
         for (int k = 1; k <= 7; k++) begin
            wc += int'(WR[3]);
            if (WR[3]) begin
               n_cmp++; if (adr(3) !== 5'(b)) begin n_err++; $display("FAIL sh_adr b=%0d got %0d", b, adr(3)); end
            end
            tick();
         end
      end
      strob[3] = 1'b0;
      for (int k = 0; k < 8; k++) begin tick(); sc += int'(shortFrame[3]); dc += int'(frameDone[3]); end
      n_cmp++; if (wc !== 28) begin n_err++; $display("FAIL sh_wr_cycles got %0d want 28", wc); end
      n_cmp++; if (sc !== 1) begin n_err++; $display("FAIL sh_short got %0d want 1", sc); end
      n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL sh_done got %0d want 0", dc); end
      n_cmp++; if (adr(3) !== 5'd0) begin n_err++; $display("FAIL sh_idle_adr got %0d want 0", adr(3)); end
      strob[3] = 1'b1;
      repeat (5) tick();
      pulse(5'b01000);
      repeat (2) tick();
      n_cmp++; if ({WR[3], adr(3)} !== 6'b1_00000) begin n_err++; $display("FAIL sh_restart got wr=%b adr=%0d want 1/0", WR[3], adr(3)); end
      repeat (6) tick();
      strob[3] = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_midreset();
      strob[1] = 1'b1;
      repeat (5) tick();
      for (int b = 0; b < 5; b++) begin pulse(5'b00010); repeat (7) tick(); end
      pulse(5'b00010);
      repeat (2) tick();
      n_cmp++; if ({WR[1], adr(1)} !== 6'b1_00101) begin n_err++; $display("FAIL mr_pre got wr=%b adr=%0d want 1/5", WR[1], adr(1)); end
      tick();
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({WR[1], adr(1)} !== 6'b0) begin n_err++; $display("FAIL mr_cut got wr=%b adr=%0d want 0/0", WR[1], adr(1)); end
      tick();
      rst = 1'b0;
      repeat (5) tick();
      pulse(5'b00010);
      repeat (2) tick();
      n_cmp++; if ({WR[1], adr(1)} !== 6'b1_00000) begin n_err++; $display("FAIL mr_restart got wr=%b adr=%0d want 1/0", WR[1], adr(1)); end
      repeat (6) tick();
   endtask

   task automatic test_parallel();
      int lr[5];
      int nb[5];
      logic ew;
      strob = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      strob = 5'h1f;
      repeat (5) tick();
      for (int c = 0; c < 5; c++) begin lr[c] = -100; nb[c] = 0; end
      for (int t = 0; t <= 65; t++) begin
         for (int c = 0; c < 5; c++) begin
            ew = t - lr[c] >= 3 && t - lr[c] <= 6;
            n_cmp++; if (WR[c] !== ew) begin n_err++; $display("FAIL par_wr c=%0d t=%0d got %b want %b", c, t, WR[c], ew); end
            if (ew) begin
               n_cmp++; if (adr(c) !== 5'(nb[c] - 1)) begin n_err++; $display("FAIL par_adr c=%0d t=%0d got %0d want %0d", c, t, adr(c), nb[c] - 1); end
            end
         end
         n_cmp++; if (overrun !== 5'b0) begin n_err++; $display("FAIL par_overrun t=%0d got %b want 0", t, overrun); end
         for (int c = 0; c < 5; c++) begin
            rxValid[c] = t >= c && (t - c) % (8 + c) == 0 && nb[c] < 5;
            if (rxValid[c]) begin lr[c] = t; nb[c]++; end
         end
         tick();
      end
      rxValid = '0;
      strob = '0;
      repeat (6) tick();
   endtask

   task automatic test_timeout();
      int sc, first;
      strob[4] = 1'b1;
      repeat (5) tick();
      for (int b = 0; b < 3; b++) begin pulse(5'b10000); if (b < 2) repeat (7) tick(); end
      sc = 0; first = -1;
      for (int k = 1; k <= 67; k++) begin
         if (shortFrame[4]) begin sc++; if (first < 0) first = k; end
         tick();
      end
      pulse(5'b10000);
      repeat (2) tick();
`ifdef WR_TIMEOUT_EN
      n_cmp++; if (sc !== 1) begin n_err++; $display("FAIL to_short got %0d want 1", sc); end
      n_cmp++; if (first !== 58) begin n_err++; $display("FAIL to_when got %0d want 58", first); end
      n_cmp++; if ({WR[4], adr(4)} !== 6'b1_00000) begin n_err++; $display("FAIL to_next got wr=%b adr=%0d want 1/0", WR[4], adr(4)); end
`else
      n_cmp++; if (sc !== 0) begin n_err++; $display("FAIL to_short got %0d want 0", sc); end
      n_cmp++; if ({WR[4], adr(4)} !== 6'b1_00011) begin n_err++; $display("FAIL to_next got wr=%b adr=%0d want 1/3", WR[4], adr(4)); end
`endif
      repeat (6) tick();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_overrun();
      test_short();
      test_midreset();
      test_parallel();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/comm_wr_adr.md
Name: comm_wr_adr

Overview:
- Write-side address sequencer for the 5-channel UART frame buffers. Channel i is the writer counterpart of the read-address sequencer that drains the same buffer.
- Per channel, a frame window strobe opens a frame. Each received byte then produces one write-address and WR pulse into the channel's 20-word buffer.
- `frameDone[i]` flags a complete frame to the downstream read sequencer.
- Sits between the UART receivers and the dual-port frame RAMs.

Parameters:
- WORDS, 20, words per frame; address wraps never, frame ends at WORDS-1.
- AW, 5, address width; WORDS must be <= 2**AW.
- WR_SETUP, 2, cycles `WrAdr` is stable before WR rises.
- WR_WIDTH, 4, cycles WR is held high.
- TIMEOUT, 1000, max idle cycles between bytes inside a frame (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- strob  in  5  per-channel frame window level; asynchronous to clk, 2-FF synchronised internally.
- rxValid  in  5  per-channel byte-received pulse, one clk wide, synchronous to clk.
- WR  out  5  per-channel RAM write strobe.
- WrAdr  out  5*AW  packed addresses; channel i occupies bits [i*AW +: AW].
- frameDone  out  5  one-cycle pulse when channel i has written word WORDS-1.
- overrun  out  5  one-cycle pulse: byte arrived while channel busy; the byte is dropped.
- shortFrame  out  5  one-cycle pulse: window closed before WORDS words were written.

Behaviour:
- Reset (async, any time, mid-frame included):
  - WR, frameDone, overrun, shortFrame = 0; `WrAdr` = 0; sync flops = 0; FSM = IDLE.
  - Any in-flight WR pulse is cut immediately.
- Synchroniser: `s = 2-FF(strob)`. All FSM decisions use s[1], giving 2-cycle strobe latency.
- Channels are fully independent; there is no inter-channel chaining.
- Per-channel FSM:
  - IDLE: count = 0, `WrAdr` = 0. Goes to ARM when s[1] = 1.
  - ARM:
    - rxValid → SETUP, set timer = 0.
    - Else if s[1] = 0: shortFrame pulse if count > 0, then → IDLE.
  - SETUP: `WrAdr` = count. After WR_SETUP cycles → PULSE with WR = 1.
  - PULSE: WR held WR_WIDTH cycles. On the last cycle WR falls on the next edge, then → NEXT.
  - NEXT (1 cycle):
    - If count == WORDS-1: frameDone pulse, count = 0 → DONE.
    - Else count = count + 1 → ARM.
  - DONE: waits for s[1] = 0, then → IDLE. rxValid here gives an overrun pulse.
- Timing: rxValid to WR rise = WR_SETUP+1 cycles. Per-byte occupancy = WR_SETUP + WR_WIDTH + 2 cycles; the minimum legal byte spacing is this value.
- rxValid in SETUP, PULSE or NEXT: overrun pulse, byte dropped, sequence unaffected.
- Window close during SETUP or PULSE: the current write completes; the close is then handled in ARM (shortFrame), or as a normal DONE if this was word WORDS-1.
- `WrAdr` holds its last value between writes and is never tri-stated. It is stable for the whole WR high period.
- count arithmetic is AW bits wide; it never exceeds WORDS-1.

Optional Feature:
- Macro: WR_TIMEOUT_EN.
- Defined:
  - In ARM with count > 0, a 16-bit gap timer counts cycles without rxValid.
  - When the timer reaches TIMEOUT, a shortFrame pulse is issued, count is reset to 0, and the FSM stays in ARM.
  - The next byte is then written at address 0.
- Undefined: no timer logic; ARM waits indefinitely.

Decomposition:
- Shared package (comm_pkg): state encodings IDLE/ARM/SETUP/PULSE/NEXT/DONE, the NCH=5 constant, and the default WORDS/AW values. The read-side sequencer reuses the same constants.
- One sub-module, comm_wr_chan: a single-channel synchroniser, FSM, counters and outputs. The top level instantiates it 5 times via generate and packs the vectors.

Test Plan:
- Nominal frame, ch0:
  - Stimulus: strob[0] = 1, then 20 rxValid pulses spaced 10 cycles.
  - Required: 20 WR pulses, each 4 cycles wide, each rising 3 cycles after rxValid, with `WrAdr` = 0..19.
  - Required: frameDone[0] pulses 1 cycle after the 20th WR falls; `WrAdr` = 0 after IDLE.
- Overrun, ch2: rxValid twice, 3 cycles apart.
  - Required: one WR at address 0; overrun[2] pulses once.
  - Required: the next valid byte is written at address 1.
- Short frame, ch3: 7 bytes, then strob[3] = 0.
  - Required: shortFrame[3] pulses once, the FSM returns to IDLE, no frameDone.
  - Required: the next frame starts at address 0.
- Mid-write reset: assert rst during PULSE of word 5 on ch1.
  - Required: WR[1] = 0 and `WrAdr` = 0 within the same cycle.
  - Required: after release with strob[1] high, the first byte is written at address 0.
- Parallel channels: all 5 channels driven with offset byte streams.
  - Required: each WR/`WrAdr` sequence matches the single-channel model; no cross-talk.
- WR_TIMEOUT_EN, TIMEOUT = 50: 3 bytes, then 60 idle cycles.
  - Required: shortFrame pulses at gap cycle 50; the next byte is written at address 0.
  - Required (macro undefined): the same stimulus writes the next byte at address 3.
